// File: rtl/div_unit_pkg.sv
// Shared ALU op-code package.
// Holds the 6-bit execute-stage op codes used by the ALU and by the
// multi-cycle divider, plus small decode helpers for the divide ops.
package div_unit_pkg;

    localparam int OP_W = 6;

    // Execute-stage ALU op codes
    localparam logic [OP_W-1:0] OPADD  = 6'd0;
    localparam logic [OP_W-1:0] OPSUB  = 6'd1;
    localparam logic [OP_W-1:0] OPAND  = 6'd2;
    localparam logic [OP_W-1:0] OPOR   = 6'd3;
    localparam logic [OP_W-1:0] OPXOR  = 6'd4;
    localparam logic [OP_W-1:0] OPSLL  = 6'd5;
    localparam logic [OP_W-1:0] OPSRL  = 6'd6;
    localparam logic [OP_W-1:0] OPSRA  = 6'd7;
    localparam logic [OP_W-1:0] OPSLT  = 6'd8;
    localparam logic [OP_W-1:0] OPSLTU = 6'd9;
    localparam logic [OP_W-1:0] OPMUL  = 6'd10;
    localparam logic [OP_W-1:0] OPDIV  = 6'd16;
    localparam logic [OP_W-1:0] OPDIVU = 6'd17;
    localparam logic [OP_W-1:0] OPREM  = 6'd18;
    localparam logic [OP_W-1:0] OPREMU = 6'd19;

    // True for the four ops serviced by the multi-cycle divider
    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
    endfunction

    // True for the signed divide/remainder ops
    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == OPDIV) || (op == OPREM);
    endfunction

    // True when the op returns the remainder rather than the quotient
    function automatic logic is_rem_op(input logic [OP_W-1:0] op);
        return (op == OPREM) || (op == OPREMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the execute stage.
// Services OPDIV, OPDIVU, OPREM and OPREMU; other op codes are ignored.
// Ports:
//   iCLK           clock, rising edge
//   iRST           asynchronous active-high reset
//   iStart         start request, sampled only while idle
//   iA, iB         dividend / divisor
//   iControlSignal ALU op code
//   oBusy          high while an operation is in flight (pipeline stall)
//   oDone          one-cycle pulse, oResult valid in that cycle
//   oResult        quotient or remainder, held until the next result
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [OP_W-1:0]  iControlSignal,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] quo_r;      // dividend shifts out MSB-first, quotient bits shift in
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic [WIDTH-1:0] dvs_r;      // divisor magnitude
    logic             neg_q_r;
    logic             neg_r_r;
    logic             rem_op_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;

    logic             serviced_s;
    logic             signed_op_s;
    logic             rem_op_s;
    logic             accept_s;
    logic             div_zero_s;
    logic             ovf_s;
    logic             bypass_s;
    logic [WIDTH-1:0] bypass_result_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] final_s;

    // Request decode, operand magnitudes and early-out detection
    always_comb begin
        serviced_s  = is_div_op(iControlSignal);
        signed_op_s = is_signed_op(iControlSignal);
        rem_op_s    = is_rem_op(iControlSignal);
        accept_s    = (state_r == ST_IDLE) && iStart && serviced_s;
        a_neg_s     = signed_op_s && iA[WIDTH-1];
        b_neg_s     = signed_op_s && iB[WIDTH-1];
        a_mag_s     = a_neg_s ? (~iA + ONE) : iA;
        b_mag_s     = b_neg_s ? (~iB + ONE) : iB;
        div_zero_s  = (iB == {WIDTH{1'b0}});
        ovf_s       = signed_op_s && (iA == MIN_NEG) && (iB == ALL_ONES);
        bypass_s    = div_zero_s || ovf_s;
        if (div_zero_s) begin
            bypass_result_s = rem_op_s ? iA : ALL_ONES;
        end else if (ovf_s) begin
            bypass_result_s = rem_op_s ? {WIDTH{1'b0}} : MIN_NEG;
        end else begin
            bypass_result_s = {WIDTH{1'b0}};
        end
    end

    // One restoring step plus the sign-corrected result of that step
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        if (!trial_s[WIDTH]) begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
        quo_fix_s = neg_q_r ? (~quo_next_s + ONE) : quo_next_s;
        rem_fix_s = neg_r_r ? (~rem_next_s + ONE) : rem_next_s;
        final_s   = rem_op_r ? rem_fix_s : quo_fix_s;
    end

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; early-out ops skip CALC entirely
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = bypass_s ? ST_DONE : ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Stall output: asserted in the accept cycle so the pipeline never misses a bubble
    always_comb begin
        oBusy = 1'b0;
        case (state_r)
            ST_IDLE: oBusy = accept_s;
            ST_CALC: oBusy = 1'b1;
            ST_DONE: oBusy = 1'b0;
            default: oBusy = 1'b0;
        endcase
    end

    // Datapath: operand capture, iteration, result load and done pulse
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt_r    <= CNT_ZERO;
            quo_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            rem_op_r <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        quo_r    <= a_mag_s;
                        rem_r    <= {WIDTH{1'b0}};
                        dvs_r    <= b_mag_s;
                        cnt_r    <= CNT_LAST;
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        rem_op_r <= rem_op_s;
                        if (bypass_s) begin
                            result_r <= bypass_result_s;
                            done_r   <= 1'b1;
                        end else begin
                            done_r   <= 1'b0;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    quo_r <= quo_next_s;
                    rem_r <= rem_next_s;
                    if (cnt_r == CNT_ZERO) begin
                        result_r <= final_s;
                        done_r   <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r - CNT_ONE;
                        done_r <= 1'b0;
                    end
                end
                ST_DONE: done_r <= 1'b0;
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign oDone   = done_r;
    assign oResult = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases followed by
// randomized operations compared against a plain-arithmetic reference.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ctrl;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .iCLK(clk), .iRST(rst), .iStart(start), .iA(a), .iB(b),
        .iControlSignal(ctrl), .oBusy(busy), .oDone(done), .oResult(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_ovf(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
        return ((op == OPDIV) || (op == OPREM)) && (x == 32'h80000000) && (y == 32'hFFFFFFFF);
    endfunction

    // Reference result from the arithmetic definition of each op
    function automatic logic [31:0] ref_div(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
        logic rem;
        rem = (op == OPREM) || (op == OPREMU);
        if (y == 32'd0) return rem ? x : 32'hFFFFFFFF;
        if (is_ovf(op, x, y)) return rem ? 32'd0 : 32'h80000000;
        case (op)
            OPDIV:   return $signed(x) / $signed(y);
            OPREM:   return $signed(x) % $signed(y);
            OPDIVU:  return x / y;
            default: return x % y;
        endcase
    endfunction

    // Issue one op (caller is just past a negedge) and check busy, latency and result.
    // If repulse > 0, iStart is pulsed again with fresh operands in that cycle.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int repulse);
        logic [31:0] exp;
        int          exp_lat;
        int          cyc;
        bit          seen;
        exp     = ref_div(op, x, y);
        exp_lat = ((y == 32'd0) || is_ovf(op, x, y)) ? 1 : 33;
        start = 1'b1; ctrl = op; a = x; b = y;
        #1;
        check({tag, " busy@0"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                check({tag, " busy"}, {31'd0, busy}, 32'd1);
                if (cyc == repulse) begin
                    start = 1'b1; ctrl = OPDIVU; a = $urandom; b = $urandom_range(1, 9);
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, " done seen"}, {31'd0, seen}, 32'd1);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " result"}, result, exp);
        check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, " done pulse"}, {31'd0, done}, 32'd0);
        check({tag, " hold"}, result, exp);
    endtask

    initial begin
        logic [5:0]  ops [4];
        logic [5:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          stray;
        ops[0] = OPDIV; ops[1] = OPDIVU; ops[2] = OPREM; ops[3] = OPREMU;
        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0; ctrl = OPADD;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);

        // First request lands on the first edge after reset release
        @(negedge clk); rst = 1'b0;
        run_op("div -7/2", OPDIV, 32'hFFFFFFF9, 32'd2, 0);
        @(negedge clk); run_op("remu ffffffff/10", OPREMU, 32'hFFFFFFFF, 32'd10, 0);
        @(negedge clk); run_op("rem -7/2", OPREM, 32'hFFFFFFF9, 32'd2, 0);
        @(negedge clk); run_op("divu by 0", OPDIVU, 32'd55, 32'd0, 0);
        @(negedge clk); run_op("rem 123/0", OPREM, 32'd123, 32'd0, 0);
        @(negedge clk); run_op("div ovf", OPDIV, 32'h80000000, 32'hFFFFFFFF, 0);
        @(negedge clk); run_op("rem ovf", OPREM, 32'h80000000, 32'hFFFFFFFF, 0);
        @(negedge clk); run_op("div repulse", OPDIV, 32'd1000, 32'hFFFFFFFD, 10);

        // Unserviced op must be ignored
        @(negedge clk); start = 1'b1; ctrl = OPADD; a = 32'd9; b = 32'd3;
        #1; check("unserviced busy", {31'd0, busy}, 32'd0);
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) stray = 1'b1;
        end
        start = 1'b0;
        check("unserviced idle", {31'd0, stray}, 32'd0);

        // Reset in the middle of a calculation
        @(negedge clk); start = 1'b1; ctrl = OPDIVU; a = 32'd5000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) stray = 1'b1;
        end
        check("abort no done", {31'd0, stray}, 32'd0);
        @(negedge clk); run_op("divu 100/7", OPDIVU, 32'd100, 32'd7, 0);

        // Randomized operations, with occasional zero / overflow / tiny divisors
        for (int n = 0; n < 24; n++) begin
            rop = ops[$urandom_range(0, 3)];
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2:       rb = $urandom_range(1, 15);
                3:       rb = 32'hFFFFFFFF - $urandom_range(0, 15);
                default: rb = $urandom;
            endcase
            @(negedge clk); run_op("random", rop, ra, rb, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
